// File: rtl/booth_product_accum.sv
// Frame accumulator placed after the 8x8 Booth multiplier.
// It sums signed 16-bit products over a frame, clamping the running sum at the
// ACC_W-bit signed limits. It presents sum, term count and an overflow flag
// through a registered output handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1. A producer holds valid and its data stable
// until that edge. in_ready is a registered decode of the state, so it never
// depends combinationally on out_ready.
module booth_product_accum #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_product,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] SAT_POS = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_NEG = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] count;
   logic             ovf;

   logic [ACC_W:0]   sum_wide;
   logic [ACC_W-1:0] sum_sat;
   logic             sat_hit;
   logic [CNT_W-1:0] count_inc;
   logic             cnt_full;
   logic             accept;
   logic             close;
   logic             ovf_next;

   // Next-term arithmetic: one guard bit catches overflow, then clamp to the signed range
   always_comb begin
      sum_wide  = {acc[ACC_W-1], acc} + {{(ACC_W-15){in_product[15]}}, in_product};
      sum_sat   = sum_wide[ACC_W-1:0];
      sat_hit   = 1'b0;
      if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
         sat_hit = 1'b1;
         sum_sat = sum_wide[ACC_W] ? SAT_NEG : SAT_POS;
      end
      count_inc = count + CNT_W'(1);
      // Reaching the all-ones count closes the frame and marks it as overflowed
      cnt_full  = (count_inc == CNT_MAX);
      accept    = in_valid & in_ready;
      close     = in_last | cnt_full;
      ovf_next  = ovf | sat_hit | cnt_full;
   end

   // Frame FSM with registered accumulator, handshake flags and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc   <= sum_sat;
                  count <= count_inc;
                  ovf   <= ovf_next;
                  if (close) begin
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_sum   <= sum_sat;
                     out_count <= count_inc;
                     out_ovf   <= ovf_next;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            HOLD: begin
               // out_valid is always 1 in HOLD, so out_ready alone completes the transfer
               if (out_ready) begin
                  state     <= IDLE;
                  acc       <= '0;
                  count     <= '0;
                  ovf       <= 1'b0;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               acc       <= '0;
               count     <= '0;
               ovf       <= 1'b0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_product_accum.sv
// Directed bench for booth_product_accum: table of short frames plus hand-written
// sequences for saturation, backpressure, count limit and mid-frame reset.
// CNT_W is widened to 9 so that a frame can be long enough to saturate a 24-bit sum.
module tb_booth_product_accum;

   localparam int ACC_W = 24;
   localparam int CNT_W = 9;
   localparam int CNT_LIMIT = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [15:0]      in_product = 16'h0000;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   int total = 0;
   int bad = 0;

   booth_product_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_product (in_product),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_count  (out_count),
      .out_ovf    (out_ovf)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      bad = bad + 1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Present one term and hold it until accepted (bounded)
   task automatic accept(input logic [15:0] p, input logic l);
      int guard;
      guard = 0;
      @(negedge clk);
      in_valid   = 1'b1;
      in_product = p;
      in_last    = l;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         total = total + 1;
         bad = bad + 1;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", guard);
      end
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      in_product = 16'hDEAD;
   endtask

   // Called #1 after the last accepted edge: check result, then do the handshake
   task automatic check_result(input string tag, input logic [ACC_W-1:0] es, input int ec,
                               input logic eo);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_sum"}, 32'(out_sum), 32'(es));
      chk({tag, "_count"}, 32'(out_count), 32'(ec));
      chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
      chk({tag, "_ready_hold"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
      chk({tag, "_sum_kept"}, 32'(out_sum), 32'(es));
   endtask

   typedef struct {
      int               n;
      logic [15:0]      p [4];
      logic [ACC_W-1:0] sum;
      int               cnt;
      logic             ovf;
   } vec_t;

   vec_t tbl [5];

   initial begin
      tbl[0].n = 4; tbl[0].p = '{16'h0010, 16'hFFF0, 16'h7FFF, 16'h0001};
      tbl[0].sum = 24'h008000; tbl[0].cnt = 4; tbl[0].ovf = 1'b0;
      tbl[1].n = 1; tbl[1].p = '{16'h8000, 16'h0000, 16'h0000, 16'h0000};
      tbl[1].sum = 24'hFF8000; tbl[1].cnt = 1; tbl[1].ovf = 1'b0;
      tbl[2].n = 2; tbl[2].p = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000};
      tbl[2].sum = 24'h00FFFE; tbl[2].cnt = 2; tbl[2].ovf = 1'b0;
      tbl[3].n = 3; tbl[3].p = '{16'h8000, 16'h8000, 16'h0005, 16'h0000};
      tbl[3].sum = 24'hFF0005; tbl[3].cnt = 3; tbl[3].ovf = 1'b0;
      tbl[4].n = 3; tbl[4].p = '{16'hFFFF, 16'hFFFF, 16'h0003, 16'h0000};
      tbl[4].sum = 24'h000001; tbl[4].cnt = 3; tbl[4].ovf = 1'b0;

      // reset with in_valid toggling
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         in_valid = ~in_valid;
         in_last  = 1'b1;
         @(negedge clk);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_in_ready", 32'(in_ready), 32'd1);
         chk("rst_out_sum", 32'(out_sum), 32'd0);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_out_count", 32'(out_count), 32'd0);

      // table of short frames
      for (int f = 0; f < 5; f++) begin
         for (int i = 0; i < tbl[f].n; i++) accept(tbl[f].p[i], (i == tbl[f].n - 1));
         check_result($sformatf("tbl%0d", f), tbl[f].sum, tbl[f].cnt, tbl[f].ovf);
      end

      // in_last without in_valid is ignored
      @(negedge clk);
      in_last = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("last_no_valid", 32'(out_valid), 32'd0);
      in_last = 1'b0;

      // backpressure: result held while a new term is offered
      accept(16'h0100, 1'b0);
      accept(16'h0200, 1'b1);
      @(negedge clk);
      in_valid = 1'b1; in_product = 16'h1234; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_sum", 32'(out_sum), 32'h000300);
         chk("bp_count", 32'(out_count), 32'd2);
      end
      in_valid = 1'b0; in_last = 1'b0;
      check_result("bp", 24'h000300, 2, 1'b0);
      accept(16'h0007, 1'b1);
      check_result("after_bp", 24'h000007, 1, 1'b0);

      // positive saturation, then a later term adds to the clamped value
      for (int i = 0; i < 257; i++) accept(16'h7FFF, 1'b0);
      accept(16'hFFFF, 1'b1);
      check_result("sat_pos", 24'h7FFFFE, 258, 1'b1);

      // negative saturation
      for (int i = 0; i < 256; i++) accept(16'h8000, 1'b0);
      accept(16'h8000, 1'b1);
      check_result("sat_neg", 24'h800000, 257, 1'b1);

      // count limit forces the frame closed
      for (int i = 0; i < CNT_LIMIT - 1; i++) accept(16'h0001, 1'b0);
      chk("cnt_not_closed", 32'(out_valid), 32'd0);
      accept(16'h0001, 1'b0);
      check_result("cnt_limit", ACC_W'(CNT_LIMIT), CNT_LIMIT, 1'b1);

      // mid-frame reset discards the partial frame
      for (int i = 0; i < 3; i++) accept(16'h0100, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_sum", 32'(out_sum), 32'd0);
      chk("mid_rst_count", 32'(out_count), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      accept(16'h0005, 1'b1);
      check_result("post_rst", 24'h000005, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
